// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for the 8:1 single-bit mux: steps sel 0..7, settles dwell+1 cycles
// per channel, samples mux_out on the last settle cycle and publishes an 8-bit result.
module mux_scan_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               done,
    output logic [NUM_CH-1:0]  result
);

    typedef enum logic [1:0] {IDLE, SETTLE, FINISH} state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [DWELL_W-1:0]   count_q, count_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [NUM_CH-1:0]    shadow_q, shadow_d;
    logic [NUM_CH-1:0]    result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            count_q  <= '0;
            dwell_q  <= '0;
            shadow_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            count_q  <= count_d;
            dwell_q  <= dwell_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) state_d = SETTLE;
            end
            SETTLE: begin
                if (abort)                                 state_d = IDLE;
                else if (count_q == '0 && sel_q == LAST_SEL) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        count_d  = count_q;
        dwell_d  = dwell_q;
        shadow_d = shadow_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    sel_d   = '0;
                    count_d = dwell;
                    dwell_d = dwell;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    sel_d  = '0;
                    busy_d = 1'b0;
                end else if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    // Last settle cycle of this channel: capture, then advance.
                    shadow_d[sel_q] = mux_out;
                    if (sel_q != LAST_SEL) begin
                        sel_d   = sel_q + 1'b1;
                        count_d = dwell_q;
                    end
                end
            end
            FINISH: begin
                sel_d  = '0;
                busy_d = 1'b0;
                if (!abort) begin
                    result_d = shadow_q;
                    done_d   = 1'b1;
                end
            end
            default: begin
                sel_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign sel    = sel_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: stimulus pushes expected done events
// into a queue, a monitor pops and compares whenever done is seen.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] dwell;
    logic       mux_out;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic [7:0] pattern = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    mux_scan_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dwell   (dwell),
        .mux_out (mux_out),
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 8:1 mux model
    assign mux_out = pattern[sel];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_scan(input logic [7:0] pat, input logic [3:0] d, input bit expect_done);
        exp_t e;
        @(negedge clk);
        pattern = pat;
        dwell   = d;
        start   = 1'b1;
        if (expect_done) begin
            e.res = pat;
            e.cyc = cyc + 1 + 8 * (int'(d) + 1) + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest expected event
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_result", int'(result), int'(e.res));
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got cycle %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int exp_sel;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dwell = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // dwell=3, dwell changed mid-scan must not alter timing
        start_scan(8'h3C, 4'd3, 1'b1);
        dwell = 4'd0;
        for (int j = 0; j <= 33; j++) begin
            exp_sel = (j == 33) ? 0 : ((j / 4 > 7) ? 7 : j / 4);
            chk("t2_sel", int'(sel), exp_sel);
            chk("t2_busy", int'(busy), (j <= 32) ? 1 : 0);
            if (j < 33) @(negedge clk);
        end
        wait_idle();
        chk("t2_result", int'(result), 8'h3C);

        // dwell=0 basic scan
        start_scan(8'hA5, 4'd0, 1'b1);
        for (int j = 0; j <= 9; j++) begin
            exp_sel = (j <= 7) ? j : ((j == 8) ? 7 : 0);
            chk("t1_sel", int'(sel), exp_sel);
            chk("t1_busy", int'(busy), (j <= 8) ? 1 : 0);
            if (j < 9) @(negedge clk);
        end
        wait_idle();
        chk("t1_result", int'(result), 8'hA5);

        // abort at sel=4: no done, result kept
        start_scan(8'hFF, 4'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("t3_sel_before_abort", int'(sel), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_busy", int'(busy), 0);
        chk("t3_sel", int'(sel), 0);
        chk("t3_done", int'(done), 0);
        chk("t3_result", int'(result), 8'hA5);
        repeat (12) @(negedge clk);
        chk("t3_result_later", int'(result), 8'hA5);
        chk("t3_busy_later", int'(busy), 0);

        // start+abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", int'(busy), 0);

        // start while busy ignored, then back-to-back start in done cycle
        start_scan(8'h81, 4'd0, 1'b1);
        repeat (2) @(negedge clk);
        chk("t4_sel", int'(sel), 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done_seen", int'(done), 1);
        begin
            exp_t e;
            pattern = 8'h5A;
            start   = 1'b1;
            e.res   = 8'h5A;
            e.cyc   = cyc + 10;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy", int'(busy), 1);
        chk("t5_done_cleared", int'(done), 0);
        wait_idle();
        chk("t5_result", int'(result), 8'h5A);

        // maximum dwell
        start_scan(8'h96, 4'd15, 1'b1);
        repeat (16) @(negedge clk);
        chk("max_dwell_sel1", int'(sel), 1);
        wait_idle();
        chk("max_dwell_result", int'(result), 8'h96);

        // asynchronous reset mid-scan
        start_scan(8'hFF, 4'd0, 1'b0);
        repeat (6) @(negedge clk);
        chk("t6_sel_before_rst", int'(sel), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_sel", int'(sel), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("t6_idle_busy", int'(busy), 0);
            chk("t6_idle_sel", int'(sel), 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
